// File: rtl/rsa_decryptor_if.sv
// Handshake bundle for rsa_decryptor: request side and result side.
// The bench drives through master, the decryptor sits on slave.
interface rsa_decryptor_if;
   logic        start;
   logic [15:0] cipher_in;
   logic        busy;
   logic        done;
   logic [15:0] plain_out;
   logic        err;

   modport master (
      output start, cipher_in,
      input  busy, done, plain_out, err
   );

   modport slave (
      input  start, cipher_in,
      output busy, done, plain_out, err
   );
endinterface

// File: rtl/rsa_decryptor.sv
// Fixed-latency RSA decryptor: square-and-multiply with shift-subtract mod.
// Optional macro RSA_DEC_INPUT_CHECK_EN rejects cipher_in >= N with err.
module rsa_decryptor #(
   parameter int          N = 3233,
   parameter logic [11:0] D = 12'd2753
) (
   input  logic            clk,
   input  logic            rst,
   rsa_decryptor_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, RED_IN, MUL_R, RED_R, MUL_B, RED_B, FIN
   } state_t;

   localparam logic [23:0] NW = 24'(N);
   localparam logic [15:0] DX = {4'b0, D};

   state_t      state, state_nx;
   logic [23:0] p;
   logic [11:0] base, result;
   logic [3:0]  idx, k;
   logic        busy_q, done_q;
   logic [15:0] plain_q;
   logic [23:0] nk, p_red;
   logic        last_k, reject;

   assign nk     = NW << k;
   assign p_red  = (p >= nk) ? p - nk : p;
   assign last_k = (k == 4'd0);

`ifdef RSA_DEC_INPUT_CHECK_EN
   logic err_q, bad;
   assign reject  = ({8'b0, bus.cipher_in} >= NW);
   assign bus.err = err_q;
`else
   assign reject  = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.plain_out = plain_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (bus.start) state_nx = reject ? FIN : RED_IN;
         RED_IN: if (last_k) state_nx = MUL_R;
         MUL_R:  state_nx = RED_R;
         RED_R:  if (last_k) state_nx = MUL_B;
         MUL_B:  state_nx = RED_B;
         RED_B:  if (last_k) state_nx = (idx == 4'd11) ? FIN : MUL_R;
         FIN:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p       <= '0;
         base    <= '0;
         result  <= '0;
         idx     <= '0;
         k       <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         plain_q <= '0;
`ifdef RSA_DEC_INPUT_CHECK_EN
         err_q   <= 1'b0;
         bad     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  p      <= {8'b0, bus.cipher_in};
                  k      <= 4'd12;
                  busy_q <= 1'b1;
`ifdef RSA_DEC_INPUT_CHECK_EN
                  err_q  <= 1'b0;
                  bad    <= reject;
`endif
               end
            end
            RED_IN, RED_R, RED_B: begin
               p <= p_red;
               k <= k - 4'd1;
               // Last reduction step also commits the now-reduced value.
               if (last_k) begin
                  if (state == RED_IN) begin
                     base   <= p_red[11:0];
                     result <= 12'd1;
                     idx    <= 4'd0;
                  end else if (state == RED_R) begin
                     if (DX[idx]) result <= p_red[11:0];
                  end else begin
                     base <= p_red[11:0];
                     idx  <= idx + 4'd1;
                  end
               end
            end
            MUL_R: begin
               p <= 24'(result) * 24'(base);
               k <= 4'd12;
            end
            MUL_B: begin
               p <= 24'(base) * 24'(base);
               k <= 4'd12;
            end
            FIN: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
`ifdef RSA_DEC_INPUT_CHECK_EN
               err_q   <= bad;
               plain_q <= bad ? 16'd0 : {4'b0, result};
`else
               plain_q <= {4'b0, result};
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_decryptor.sv
// Directed + randomized bench for rsa_decryptor against a modpow model.
// Honours RSA_DEC_INPUT_CHECK_EN for the out-of-range input case.
module tb_rsa_decryptor;

   localparam int NMOD = 3233;
   localparam int DEXP = 2753;
   localparam int LAT  = 350;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   rsa_decryptor_if cif();

   rsa_decryptor #(.N(NMOD), .D(12'(DEXP))) dut (
      .clk (clk),
      .rst (rst),
      .bus (cif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint modpow(longint b, longint e, longint n);
      longint r = 1;
      b = b % n;
      for (longint i = 0; i < e; i++) r = (r * b) % n;
      return r;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One operation; optional start pulses while busy must not matter.
   task automatic run_op(input int c, input longint exp_plain,
                         input int exp_lat, input int exp_err,
                         input bit poke, input string tag);
      int n;
      bit seen;
      @(negedge clk);
      cif.cipher_in = 16'(c);
      cif.start     = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_busy_acc"}, longint'(cif.busy), 1);
      cif.start     = 1'b0;
      cif.cipher_in = 16'($urandom);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (cif.done) seen = 1'b1;
         else if (poke) cif.start = (n >= 40 && n < 60);
      end
      cif.start = 1'b0;
      chk({tag, "_done_seen"}, longint'(seen), 1);
      chk({tag, "_latency"}, longint'(n), longint'(exp_lat));
      chk({tag, "_plain"}, longint'(cif.plain_out), exp_plain);
      chk({tag, "_err"}, longint'(cif.err), longint'(exp_err));
      @(posedge clk);
      #1;
      chk({tag, "_done_clr"}, longint'(cif.done), 0);
      chk({tag, "_busy_clr"}, longint'(cif.busy), 0);
   endtask

   initial begin
      int c;
      int m;
      int n;
      int ndone;
      int pos[3];
      bit bad_done;

      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      cif.start     = 1'b1;
      cif.cipher_in = 16'd2790;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", longint'(cif.busy), 0);
      chk("rst_done", longint'(cif.done), 0);
      chk("rst_plain", longint'(cif.plain_out), 0);
      chk("rst_err", longint'(cif.err), 0);
      cif.start = 1'b0;
      rst       = 1'b0;

      run_op(2790, 65, LAT, 0, 1'b0, "basic");
      run_op(2790, 65, LAT, 0, 1'b1, "poke");

      for (int i = 0; i < 8; i++) begin
         m = (i < 4) ? i : int'($urandom_range(4, 255));
         c = int'(modpow(m, 17, NMOD));
         run_op(c, m, LAT, 0, 1'b0, $sformatf("sweep_m%0d", m));
      end

      for (int i = 0; i < 6; i++) begin
         c = int'($urandom_range(0, NMOD - 1));
         run_op(c, modpow(c, DEXP, NMOD), LAT, 0, 1'b0,
                $sformatf("rand_c%0d", c));
      end
      run_op(NMOD - 1, modpow(NMOD - 1, DEXP, NMOD), LAT, 0, 1'b0, "c_nm1");

      // Abort mid-operation, then a full restart.
      @(negedge clk);
      cif.cipher_in = 16'd2790;
      cif.start     = 1'b1;
      @(posedge clk);
      #1;
      cif.start = 1'b0;
      bad_done  = 1'b0;
      for (int e = 1; e < 100; e++) begin
         @(posedge clk);
         #1;
         if (cif.done) bad_done = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_no_done", longint'(bad_done), 0);
      chk("abort_busy", longint'(cif.busy), 0);
      chk("abort_done", longint'(cif.done), 0);
      chk("abort_plain", longint'(cif.plain_out), 0);
      chk("abort_err", longint'(cif.err), 0);
      run_op(855, modpow(855, DEXP, NMOD), LAT, 0, 1'b0, "restart");

      // Held start: three back-to-back operations.
      @(negedge clk);
      cif.cipher_in = 16'd2790;
      cif.start     = 1'b1;
      @(posedge clk);
      #1;
      n     = 0;
      ndone = 0;
      while (ndone < 3 && n < 1200) begin
         @(posedge clk);
         #1;
         n++;
         if (cif.done) begin
            pos[ndone] = n;
            chk($sformatf("b2b_plain%0d", ndone), longint'(cif.plain_out), 65);
            ndone++;
         end
      end
      cif.start = 1'b0;
      chk("b2b_count", longint'(ndone), 3);
      if (ndone == 3) begin
         chk("b2b_first", longint'(pos[0]), LAT);
         chk("b2b_gap1", longint'(pos[1] - pos[0]), LAT + 1);
         chk("b2b_gap2", longint'(pos[2] - pos[1]), LAT + 1);
      end
      @(posedge clk);
      #1;
      chk("b2b_idle", longint'(cif.busy), 0);

`ifdef RSA_DEC_INPUT_CHECK_EN
      run_op(NMOD, 0, 1, 1, 1'b0, "illegal_n");
      run_op(65535, 0, 1, 1, 1'b0, "illegal_max");
      run_op(2790, 65, LAT, 0, 1'b0, "after_illegal");
`else
      run_op(NMOD, 0, LAT, 0, 1'b0, "wrap_n");
      run_op(65535, modpow(65535, DEXP, NMOD), LAT, 0, 1'b0, "wrap_max");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
